// File: rtl/theta_current_inverse.sv
// Bisection inverse of an external combinational current-to-theta LUT: finds the smallest
// current whose LUT theta reaches the target. Define THETA_CURRENT_CACHE_EN to reuse the last result.
module theta_current_inverse #(
  parameter logic signed [31:0] CURRENT_MIN = 32'sd0,
  parameter logic signed [31:0] CURRENT_MAX = 32'sd314,
  parameter int                 ITER        = 9
) (
  input  logic        i_clock,
  input  logic        i_reset_n,
  input  logic        i_start,
  input  logic [31:0] i_theta,
  output logic        o_busy,
  output logic        o_done,
  output logic [31:0] o_current,
  output logic        o_exact,
  output logic [31:0] o_probe_current,
  input  logic [31:0] i_probe_theta
);

  localparam int             CNT_W    = (ITER > 1) ? $clog2(ITER) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER - 1);

  typedef enum logic [1:0] {IDLE, SEARCH, FINISH} state_t;

  state_t             state_q;
  logic signed [31:0] lo_q, hi_q, target_q, current_q;
  logic signed [31:0] lo_d, hi_d, mid, probe_theta;
  logic [CNT_W-1:0]   cnt_q;
  logic               busy_q, done_q, exact_q;

`ifdef THETA_CURRENT_CACHE_EN
  logic signed [31:0] cache_tgt_q, cache_cur_q;
  logic               cache_vld_q;
`endif

  // Widened to 33 bits so extreme signed bounds cannot overflow the span.
  function automatic logic signed [31:0] midpoint(input logic signed [31:0] lo,
                                                  input logic signed [31:0] hi);
    logic signed [32:0] span;
    logic signed [32:0] m;
    span = {hi[31], hi} - {lo[31], lo};
    m    = {lo[31], lo} + (span >>> 1);
    return m[31:0];
  endfunction

  assign probe_theta = $signed(i_probe_theta);
  assign mid         = midpoint(lo_q, hi_q);

  // Never step lo past hi, so a degenerate range still converges on CURRENT_MAX.
  always_comb begin
    lo_d = lo_q;
    hi_d = hi_q;
    if (probe_theta >= target_q) hi_d = mid;
    else if (mid != hi_q)        lo_d = mid + 32'sd1;
  end

  always_comb begin
    case (state_q)
      SEARCH:  o_probe_current = mid;
      FINISH:  o_probe_current = lo_q;
      default: o_probe_current = current_q;
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q     <= IDLE;
      lo_q        <= '0;
      hi_q        <= '0;
      target_q    <= '0;
      cnt_q       <= '0;
      current_q   <= CURRENT_MIN;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      exact_q     <= 1'b0;
`ifdef THETA_CURRENT_CACHE_EN
      cache_tgt_q <= '0;
      cache_cur_q <= '0;
      cache_vld_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (i_start) begin
            target_q <= $signed(i_theta);
            lo_q     <= CURRENT_MIN;
            hi_q     <= CURRENT_MAX;
            cnt_q    <= '0;
            busy_q   <= 1'b1;
            state_q  <= SEARCH;
`ifdef THETA_CURRENT_CACHE_EN
            if (cache_vld_q && ($signed(i_theta) == cache_tgt_q)) begin
              lo_q    <= cache_cur_q;
              state_q <= FINISH;
            end
`endif
          end
        end
        SEARCH: begin
          lo_q  <= lo_d;
          hi_q  <= hi_d;
          cnt_q <= cnt_q + CNT_W'(1);
          if ((lo_d == hi_d) || (cnt_q == CNT_LAST)) state_q <= FINISH;
        end
        FINISH: begin
          current_q <= lo_q;
          exact_q   <= (probe_theta == target_q);
          done_q    <= 1'b1;
          busy_q    <= 1'b0;
          state_q   <= IDLE;
`ifdef THETA_CURRENT_CACHE_EN
          cache_tgt_q <= target_q;
          cache_cur_q <= lo_q;
          cache_vld_q <= 1'b1;
`endif
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_busy    = busy_q;
  assign o_done    = done_q;
  assign o_current = current_q;
  assign o_exact   = exact_q;

endmodule

// File: tb/tb_theta_current_inverse.sv
// Bench for theta_current_inverse: directed vector table, corner sequences and randomized
// searches against a linear-scan reference over the bench-owned LUT.
module tb_theta_current_inverse;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, start2;
  logic [31:0] theta, theta2;
  logic        busy, done, exact, busy2, done2, exact2;
  logic [31:0] cur, probe, ptheta, cur2, probe2, ptheta2;

  int checks = 0;
  int errors = 0;
  int lut_mode = 0;
  int tab [0:314];

  always #5 clk = ~clk;

  theta_current_inverse #(.CURRENT_MIN(0), .CURRENT_MAX(314), .ITER(9)) dut (
    .i_clock(clk), .i_reset_n(rst_n), .i_start(start), .i_theta(theta),
    .o_busy(busy), .o_done(done), .o_current(cur), .o_exact(exact),
    .o_probe_current(probe), .i_probe_theta(ptheta));

  theta_current_inverse #(.CURRENT_MIN(7), .CURRENT_MAX(7), .ITER(1)) dut2 (
    .i_clock(clk), .i_reset_n(rst_n), .i_start(start2), .i_theta(theta2),
    .o_busy(busy2), .o_done(done2), .o_current(cur2), .o_exact(exact2),
    .o_probe_current(probe2), .i_probe_theta(ptheta2));

  always_comb begin
    int pc;
    pc = $signed(probe);
    ptheta = 32'd0;
    if (lut_mode == 0)          ptheta = 32'(2 * pc);
    else if (pc >= 0 && pc <= 314) ptheta = 32'(tab[pc]);
  end

  always_comb begin
    int pc2;
    pc2 = $signed(probe2);
    ptheta2 = 32'(2 * pc2);
  end

  function automatic int lut_at(input int c);
    return (lut_mode == 0) ? 2 * c : tab[c];
  endfunction

  // Smallest current in range whose LUT theta reaches the target, else the top of the range.
  function automatic int ref_cur(input int th);
    for (int c = 0; c <= 314; c++)
      if (lut_at(c) >= th) return c;
    return 314;
  endfunction

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Called at a negedge; returns the result, edge count from the accepting edge to the
  // first cycle with done high, and a count of handshake anomalies.
  task automatic run(input bit sel, input int th, output int rcur, output int rex,
                     output int lat, output int proto);
    proto = 0;
    if (sel) begin start2 = 1'b1; theta2 = 32'(th); end
    else     begin start  = 1'b1; theta  = 32'(th); end
    @(negedge clk);
    start = 1'b0; start2 = 1'b0;
    theta = 32'(~th); theta2 = 32'(~th);
    lat = 1;
    while (!(sel ? done2 : done) && lat < 40) begin
      if (!(sel ? busy2 : busy)) proto++;
      @(negedge clk);
      lat++;
    end
    if (sel ? busy2 : busy) proto++;
    rcur = sel ? $signed(cur2) : $signed(cur);
    rex  = sel ? int'(exact2) : int'(exact);
    @(negedge clk);
    if (sel ? done2 : done) proto++;
  endtask

  typedef struct {int th; int exp_cur; int exp_ex;} vec_t;

  initial begin
    vec_t vecs [9];
    int rc, rx, lat, pr, n, th;

    vecs[0] = '{100, 50, 1};   vecs[1] = '{101, 51, 0};  vecs[2] = '{1000, 314, 0};
    vecs[3] = '{-5, 0, 0};     vecs[4] = '{0, 0, 1};     vecs[5] = '{628, 314, 1};
    vecs[6] = '{627, 314, 0};  vecs[7] = '{629, 314, 0}; vecs[8] = '{1, 1, 0};

    tab[0] = -20 + int'($urandom_range(0, 10));
    for (int c = 1; c <= 314; c++) tab[c] = tab[c-1] + int'($urandom_range(0, 3));

    rst_n = 1'b0; start = 1'b0; start2 = 1'b0; theta = '0; theta2 = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_exact", int'(exact), 0);
    check("rst_current", $signed(cur), 0);
    check("rst_probe", $signed(probe), 0);
    check("rst_current_min7", $signed(cur2), 7);
    check("rst_probe_min7", $signed(probe2), 7);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 9; i++) begin
      run(1'b0, vecs[i].th, rc, rx, lat, pr);
      check($sformatf("vec%0d_current", i), rc, vecs[i].exp_cur);
      check($sformatf("vec%0d_exact", i), rx, vecs[i].exp_ex);
      check($sformatf("vec%0d_latency_ok", i), int'(lat <= 11), 1);
      check($sformatf("vec%0d_handshake", i), pr, 0);
    end

    // Start while busy is ignored.
    start = 1'b1; theta = 32'd200;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk); start = 1'b1; theta = 32'd10;
    @(negedge clk); start = 1'b0;
    n = 0; rc = -1; rx = -1;
    for (int k = 0; k < 20; k++) begin
      if (done) begin n++; rc = $signed(cur); rx = int'(exact); end
      @(negedge clk);
    end
    check("busy_ign_done_count", n, 1);
    check("busy_ign_current", rc, 100);
    check("busy_ign_exact", rx, 1);

    // Reset in the middle of a search.
    start = 1'b1; theta = 32'd200;
    @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_busy", int'(busy), 0);
    check("midrst_current", $signed(cur), 0);
    check("midrst_probe", $signed(probe), 0);
    check("midrst_exact", int'(exact), 0);
    n = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (done) n++;
    end
    check("midrst_no_done", n, 0);
    rst_n = 1'b1;
    @(negedge clk);
    run(1'b0, 6, rc, rx, lat, pr);
    check("after_rst_current", rc, 3);
    check("after_rst_exact", rx, 1);

    // Repeated target, then a fresh one.
    run(1'b0, 100, rc, rx, lat, pr);
    check("rep1_current", rc, 50);
    run(1'b0, 100, rc, rx, lat, pr);
    check("rep2_current", rc, 50);
    check("rep2_exact", rx, 1);
`ifdef THETA_CURRENT_CACHE_EN
    check("rep2_cached_latency", lat, 2);
`else
    check("rep2_full_latency", int'(lat > 2 && lat <= 11), 1);
`endif
    run(1'b0, 102, rc, rx, lat, pr);
    check("fresh_current", rc, 51);
    check("fresh_exact", rx, 1);
    check("fresh_full_latency", int'(lat > 2 && lat <= 11), 1);

    // Single-point range.
    run(1'b1, 0, rc, rx, lat, pr);
    check("pt_th0_current", rc, 7);
    check("pt_th0_exact", rx, 0);
    check("pt_th0_latency", lat, 3);
    check("pt_th0_handshake", pr, 0);
    run(1'b1, 14, rc, rx, lat, pr);
    check("pt_th14_current", rc, 7);
    check("pt_th14_exact", rx, 1);
    check("pt_th14_latency", lat, 3);
    run(1'b1, 100, rc, rx, lat, pr);
    check("pt_th100_current", rc, 7);
    check("pt_th100_exact", rx, 0);
    check("pt_th100_latency", lat, 3);

    // Randomized targets against a random monotonic LUT; reset first so no stale cached result.
    rst_n = 1'b0;
    @(negedge clk);
    lut_mode = 1;
    rst_n = 1'b1;
    @(negedge clk);
    th = 0;
    for (int i = 0; i < 40; i++) begin
      if (i == 0 || $urandom_range(0, 4) != 0)
        th = tab[0] - 10 + int'($urandom_range(0, 32'(tab[314] - tab[0] + 20)));
      run(1'b0, th, rc, rx, lat, pr);
      check($sformatf("rnd%0d_th%0d_current", i, th), rc, ref_cur(th));
      check($sformatf("rnd%0d_th%0d_exact", i, th), rx, int'(lut_at(ref_cur(th)) == th));
      check($sformatf("rnd%0d_latency_ok", i), int'(lat <= 11), 1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
